// File: rtl/score_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : score_sequencer
// Purpose  : Fetches 16-bit score words, absorbs BPM commands, and hands each
//            note word to the timing controller, waiting for its DONE.
// Options  : SCORE_SEQ_LOOP_EN - wrap to BASE_ADDR instead of finishing.
// Revision : 1.0 - initial release
// ============================================================================
module score_sequencer #(
    parameter int                ADDR_W    = 23,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1,
    parameter logic [7:0]        BPM_INIT  = 8'd80
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic [15:0]       WORD_IN,
    input  logic              WORD_VALID,
    output logic              WORD_REQ,
    output logic [ADDR_W-1:0] ADDR,
    input  logic              NOTE_DONE,
    output logic              NOTE_LOAD,
    output logic [1:0]        MODE,
    output logic [5:0]        TONE,
    output logic [3:0]        NOTE,
    output logic [7:0]        BPM,
    output logic              PLAYING,
    output logic              FINISHED
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_PLAY   = 3'd4,
        S_END    = 3'd5
    } state_t;

    localparam logic [15:0]       c_END_MARKER = 16'hC000;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       word_q, word_d;
    logic [7:0]        bpm_q, bpm_d;
    logic [1:0]        mode_q, mode_d;
    logic [5:0]        tone_q, tone_d;
    logic [3:0]        note_q, note_d;
    logic              word_req_q, word_req_d;
    logic              note_load_q, note_load_d;
    logic              playing_q, playing_d;
    logic              finished_q, finished_d;

    logic              is_bpm;
    logic              is_end;
    state_t            adv_state;
    logic [ADDR_W-1:0] adv_addr;
    state_t            term_state;
    logic [ADDR_W-1:0] term_addr;

    assign is_bpm = (word_q[15:14] == 2'b11);
    assign is_end = (word_q == c_END_MARKER);

    // Where to go after a word is consumed, and where the end marker leads.
    always_comb begin
        adv_state  = S_FETCH;
        adv_addr   = addr_q + c_ADDR_ONE;
`ifdef SCORE_SEQ_LOOP_EN
        term_state = S_FETCH;
        term_addr  = BASE_ADDR;
        if (addr_q == LAST_ADDR) begin
            adv_state = S_FETCH;
            adv_addr  = BASE_ADDR;
        end
`else
        term_state = S_END;
        term_addr  = addr_q;
        if (addr_q == LAST_ADDR) begin
            adv_state = S_END;
            adv_addr  = addr_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        bpm_d       = bpm_q;
        mode_d      = mode_q;
        tone_d      = tone_q;
        note_d      = note_q;
        word_req_d  = 1'b0;
        note_load_d = 1'b0;
        playing_d   = playing_q;
        finished_d  = finished_q;

        if (STOP && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            tone_d     = '0;
            playing_d  = 1'b0;
            finished_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_END: begin
                    if (START) begin
                        state_d    = S_FETCH;
                        addr_d     = BASE_ADDR;
                        playing_d  = 1'b1;
                        finished_d = 1'b0;
                    end
                end
                S_FETCH: begin
                    word_req_d = 1'b1;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (WORD_VALID) begin
                        word_d  = WORD_IN;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_end) begin
                        state_d = term_state;
                        addr_d  = term_addr;
                    end else if (is_bpm) begin
                        bpm_d   = word_q[7:0];
                        state_d = adv_state;
                        addr_d  = adv_addr;
                    end else begin
                        mode_d      = word_q[15:14];
                        tone_d      = word_q[13:8];
                        note_d      = word_q[3:0];
                        note_load_d = 1'b1;
                        state_d     = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (NOTE_DONE) begin
                        state_d = adv_state;
                        addr_d  = adv_addr;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Entering or sitting in END always presents a muted, finished player.
        if (state_d == S_END) begin
            playing_d  = 1'b0;
            finished_d = 1'b1;
            tone_d     = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            addr_q      <= BASE_ADDR;
            word_q      <= '0;
            bpm_q       <= BPM_INIT;
            mode_q      <= '0;
            tone_q      <= '0;
            note_q      <= '0;
            word_req_q  <= 1'b0;
            note_load_q <= 1'b0;
            playing_q   <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            bpm_q       <= bpm_d;
            mode_q      <= mode_d;
            tone_q      <= tone_d;
            note_q      <= note_d;
            word_req_q  <= word_req_d;
            note_load_q <= note_load_d;
            playing_q   <= playing_d;
            finished_q  <= finished_d;
        end
    end

    assign WORD_REQ  = word_req_q;
    assign ADDR      = addr_q;
    assign NOTE_LOAD = note_load_q;
    assign MODE      = mode_q;
    assign TONE      = tone_q;
    assign NOTE      = note_q;
    assign BPM       = bpm_q;
    assign PLAYING   = playing_q;
    assign FINISHED  = finished_q;

endmodule
`default_nettype wire

// File: tb/tb_score_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_score_sequencer
// Purpose  : Directed self-checking bench for score_sequencer (LAST_ADDR = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_sequencer;

    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          STOP = 1'b0;
    logic [15:0]   WORD_IN = 16'h0;
    logic          WORD_VALID = 1'b0;
    logic          NOTE_DONE = 1'b0;
    logic          WORD_REQ;
    logic [AW-1:0] ADDR;
    logic          NOTE_LOAD;
    logic [1:0]    MODE;
    logic [5:0]    TONE;
    logic [3:0]    NOTE;
    logic [7:0]    BPM;
    logic          PLAYING;
    logic          FINISHED;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [11:0]   exp_q[$];

    score_sequencer #(
        .ADDR_W    (AW),
        .BASE_ADDR (4'd0),
        .LAST_ADDR (4'd3),
        .BPM_INIT  (8'd80)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .STOP       (STOP),
        .WORD_IN    (WORD_IN),
        .WORD_VALID (WORD_VALID),
        .WORD_REQ   (WORD_REQ),
        .ADDR       (ADDR),
        .NOTE_DONE  (NOTE_DONE),
        .NOTE_LOAD  (NOTE_LOAD),
        .MODE       (MODE),
        .TONE       (TONE),
        .NOTE       (NOTE),
        .BPM        (BPM),
        .PLAYING    (PLAYING),
        .FINISHED   (FINISHED)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
    endtask

    task automatic pulse_done();
        NOTE_DONE = 1'b1;
        tick();
        NOTE_DONE = 1'b0;
    endtask

    task automatic wait_req(input logic [AW-1:0] a, input string tag);
        int k = 0;
        while (WORD_REQ !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, " req"}, WORD_REQ, 1);
        check({tag, " addr"}, ADDR, a);
    endtask

    // Note words are scoreboarded when the memory reply is driven.
    task automatic reply(input logic [15:0] w, input string tag);
        if (w[15:14] != 2'b11)
            exp_q.push_back({w[15:14], w[13:8], w[3:0]});
        WORD_IN    = w;
        WORD_VALID = 1'b1;
        tick();
        WORD_VALID = 1'b0;
        WORD_IN    = 16'h0;
        check({tag, " req one cycle"}, WORD_REQ, 0);
    endtask

    task automatic wait_load(input string tag);
        int k = 0;
        logic [11:0] e;
        while (NOTE_LOAD !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check({tag, " load latency"}, k, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        check({tag, " mode/tone/note"}, {MODE, TONE, NOTE}, e);
        tick();
        check({tag, " load pulse"}, NOTE_LOAD, 0);
    endtask

    initial begin
        logic [15:0] ws [4];
        logic        seen;
        ws[0] = 16'h0111;
        ws[1] = 16'h4222;
        ws[2] = 16'h8333;
        ws[3] = 16'h0F0F;

        // Reset and idle
        repeat (3) tick();
        RST = 1'b0;
        repeat (10) tick();
        check("rst bpm", BPM, 8'd80);
        check("rst addr", ADDR, 0);
        check("rst tone", TONE, 0);
        check("rst req", WORD_REQ, 0);
        check("rst load", NOTE_LOAD, 0);
        check("rst playing", PLAYING, 0);
        check("rst finished", FINISHED, 0);

        // First note, start latency, hold until DONE
        pulse_start();
        check("start playing", PLAYING, 1);
        check("start req early", WORD_REQ, 0);
        tick();
        check("start req lat2", WORD_REQ, 1);
        check("start addr", ADDR, 0);
        reply(16'h0A05, "n0");
        wait_load("n0");
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | WORD_REQ;
        end
        check("play no req", seen, 0);
        pulse_done();
        wait_req(1, "n0 next");
        pulse_stop();
        check("stop wait playing", PLAYING, 0);
        check("stop wait addr", ADDR, 1);

        // BPM command, note, end marker
        pulse_start();
        wait_req(0, "s1 w0");
        reply(16'hC078, "s1 bpm");
        tick();
        check("s1 bpm val", BPM, 8'h78);
        check("s1 bpm no load", NOTE_LOAD, 0);
        wait_req(1, "s1 w1");
        reply(16'h4203, "s1 n1");
        wait_load("s1 n1");
        pulse_done();
        wait_req(2, "s1 w2");
        reply(16'hC000, "s1 end");
        tick();
`ifdef SCORE_SEQ_LOOP_EN
        wait_req(0, "s1 loop");
        check("s1 loop finished", FINISHED, 0);
        check("s1 loop playing", PLAYING, 1);
        pulse_stop();
`else
        check("s1 finished", FINISHED, 1);
        check("s1 playing", PLAYING, 0);
        check("s1 tone", TONE, 0);
`endif
        check("s1 bpm kept", BPM, 8'h78);

        // STOP together with NOTE_DONE
        pulse_start();
        wait_req(0, "s2 w0");
        reply(16'h8105, "s2 n0");
        wait_load("s2 n0");
        NOTE_DONE = 1'b1;
        STOP      = 1'b1;
        tick();
        NOTE_DONE = 1'b0;
        STOP      = 1'b0;
        check("s2 stop playing", PLAYING, 0);
        check("s2 stop tone", TONE, 0);
        check("s2 stop addr", ADDR, 0);
        check("s2 stop finished", FINISHED, 0);
        seen = 1'b0;
        repeat (3) begin
            tick();
            seen = seen | WORD_REQ;
        end
        check("s2 idle no req", seen, 0);
        pulse_start();
        wait_req(0, "s2 restart");
        check("s2 bpm kept", BPM, 8'h78);

        // Four notes up to LAST_ADDR
        for (int i = 0; i < 4; i++) begin
            reply(ws[i], "s3 note");
            wait_load("s3 note");
            pulse_done();
            if (i < 3)
                wait_req(i + 1, "s3 next");
        end
`ifdef SCORE_SEQ_LOOP_EN
        wait_req(0, "s3 wrap");
        check("s3 wrap finished", FINISHED, 0);
`else
        check("s3 finished", FINISHED, 1);
        check("s3 playing", PLAYING, 0);
        check("s3 addr", ADDR, 3);
`endif

        // Consecutive BPM commands
        pulse_stop();
        pulse_start();
        wait_req(0, "s4 w0");
        reply(16'hC010, "s4 bpm0");
        tick();
        check("s4 bpm first", BPM, 8'h10);
        wait_req(1, "s4 w1");
        reply(16'hC020, "s4 bpm1");
        tick();
        check("s4 bpm last", BPM, 8'h20);
        pulse_stop();
        check("s4 stop in fetch req", WORD_REQ, 0);
        check("s4 stop bpm", BPM, 8'h20);

        // Stray WORD_VALID / NOTE_DONE while idle
        WORD_IN    = 16'h0A05;
        WORD_VALID = 1'b1;
        NOTE_DONE  = 1'b1;
        tick();
        WORD_VALID = 1'b0;
        NOTE_DONE  = 1'b0;
        WORD_IN    = 16'h0;
        repeat (3) tick();
        check("idle ign addr", ADDR, 2);
        check("idle ign playing", PLAYING, 0);
        check("idle ign load", NOTE_LOAD, 0);
        check("idle ign req", WORD_REQ, 0);
        check("idle ign tone", TONE, 0);
        check("idle ign finished", FINISHED, 0);

        // START while playing is ignored
        pulse_start();
        wait_req(0, "s5 w0");
        reply(16'h4707, "s5 n0");
        wait_load("s5 n0");
        pulse_start();
        repeat (3) tick();
        check("s5 ign addr", ADDR, 0);
        check("s5 ign load", NOTE_LOAD, 0);
        check("s5 ign req", WORD_REQ, 0);
        check("s5 ign tone", TONE, 7);
        check("s5 ign playing", PLAYING, 1);
        pulse_done();
        wait_req(1, "s5 next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
